// File: rtl/ben_cpu_pkg.sv
// ============================================================================
// ben_cpu_pkg -- shared widths and control-state encoding for the ben CPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ben_cpu_pkg;

    localparam int ADDR_W_DEFAULT = 4;
    localparam int INSTR_W        = 8;
    localparam int STEP_W         = 3;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// program_counter -- loadable, wrapping program counter with clock enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_counter #(
    parameter int ADDR_W = ben_cpu_pkg::ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // Load has priority; increment wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (en) begin
            if (load) begin
                pc <= load_addr;
            end else if (inc) begin
                pc <= pc + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl -- FETCH/EXEC/HALT sequencer driving the program store and IR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl
    import ben_cpu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int EXEC_STEPS = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_halt,
    input  logic               i_done,
    input  logic               i_jump,
    input  logic [ADDR_W-1:0]  i_jump_addr,
    input  logic [INSTR_W-1:0] i_rom_data,
    output logic               o_rom_en,
    output logic [ADDR_W-1:0]  o_rom_addr,
    output logic [INSTR_W-1:0] o_ir,
    output logic [STEP_W-1:0]  o_step,
    output logic               o_exec,
    output logic               o_halted,
    output logic [ADDR_W-1:0]  o_pc
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(EXEC_STEPS - 1);

    ctrl_state_t        state;
    ctrl_state_t        state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] ir_nxt;
    logic [STEP_W-1:0]  step;
    logic [STEP_W-1:0]  step_nxt;
    logic               pc_inc;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_FETCH;
            ir    <= '0;
            step  <= '0;
        end else if (i_run) begin
            state <= state_nxt;
            ir    <= ir_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        step_nxt  = step;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        case (state)
            ST_FETCH: begin
                ir_nxt    = i_rom_data;
                step_nxt  = '0;
                pc_inc    = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                // Halt wins over jump and done; the instruction state is kept.
                if (i_halt) begin
                    state_nxt = ST_HALT;
                end else begin
                    pc_load = i_jump;
                    if (i_done || (step == LAST_STEP)) begin
                        state_nxt = ST_FETCH;
                        step_nxt  = '0;
                    end else begin
                        step_nxt  = step + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    program_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk       (i_clk),
        .rst       (i_reset),
        .en        (i_run),
        .load      (pc_load),
        .load_addr (i_jump_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    assign o_rom_en   = (state == ST_FETCH);
    assign o_rom_addr = pc;
    assign o_pc       = pc;
    assign o_ir       = ir;
    assign o_step     = step;
    assign o_exec     = (state == ST_EXEC);
    assign o_halted   = (state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl -- table, directed and randomized checks of fetch_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    localparam int EXEC_STEPS = 3;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_run = 1'b0;
    logic       i_halt = 1'b0;
    logic       i_done = 1'b0;
    logic       i_jump = 1'b0;
    logic [3:0] i_jump_addr = 4'h0;
    logic [7:0] i_rom_data;
    logic       o_rom_en;
    logic [3:0] o_rom_addr;
    logic [7:0] o_ir;
    logic [2:0] o_step;
    logic       o_exec;
    logic       o_halted;
    logic [3:0] o_pc;

    logic [7:0] rom [16];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 = fetch, 1 = execute, 2 = halted.
    int         m_phase;
    int         m_pc;
    int         m_step;
    logic [7:0] m_ir;

    fetch_ctrl #(
        .ADDR_W     (4),
        .EXEC_STEPS (EXEC_STEPS)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_run       (i_run),
        .i_halt      (i_halt),
        .i_done      (i_done),
        .i_jump      (i_jump),
        .i_jump_addr (i_jump_addr),
        .i_rom_data  (i_rom_data),
        .o_rom_en    (o_rom_en),
        .o_rom_addr  (o_rom_addr),
        .o_ir        (o_ir),
        .o_step      (o_step),
        .o_exec      (o_exec),
        .o_halted    (o_halted),
        .o_pc        (o_pc)
    );

    always #5 i_clk = ~i_clk;

    assign i_rom_data = rom[o_rom_addr];

    typedef struct {
        logic       run, halt, done, jump;
        logic [3:0] ja;
        logic       e_en;
        logic [3:0] e_pc;
        logic [7:0] e_ir;
        logic [2:0] e_step;
        logic       e_exec, e_halt;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [21:0] actual_bus();
        return {o_rom_en, o_rom_addr, o_ir, o_step, o_exec, o_halted, o_pc};
    endfunction

    task automatic compare(input string name, input logic [21:0] act, input logic [21:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got en/addr/ir/step/exec/halt/pc=%h, want %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [21:0] exp;
        exp = {m_phase == 0, 4'(m_pc), m_ir, 3'(m_step), m_phase == 1, m_phase == 2, 4'(m_pc)};
        compare(name, actual_bus(), exp);
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 0;
        m_step  = 0;
        m_ir    = 8'h00;
    endtask

    task automatic apply(input logic run, input logic halt, input logic done,
                         input logic jump, input logic [3:0] ja);
        i_run = run; i_halt = halt; i_done = done; i_jump = jump; i_jump_addr = ja;
        @(posedge i_clk);
        if (run) begin
            case (m_phase)
                0: begin
                    m_ir    = rom[m_pc];
                    m_pc    = (m_pc + 1) % 16;
                    m_step  = 0;
                    m_phase = 1;
                end
                1: begin
                    if (halt) begin
                        m_phase = 2;
                    end else begin
                        if (jump) m_pc = ja;
                        if (done || m_step == EXEC_STEPS - 1) begin
                            m_phase = 0;
                            m_step  = 0;
                        end else begin
                            m_step = m_step + 1;
                        end
                    end
                end
                default: ;
            endcase
        end
        #1;
    endtask

    // Called 1 time unit after an edge; pulses reset well clear of the next edge.
    task automatic async_reset(input string name);
        #2 i_reset = 1'b1;
        #1;
        model_reset();
        check_model(name);
        #3 i_reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'(8'h80 + i);
        rom[0] = 8'h1E; rom[1] = 8'h22; rom[2] = 8'h55; rom[10] = 8'h33;

        tbl[0]  = '{1,0,0,0,4'h0, 0,4'h1,8'h1E,3'd0,1,0};
        tbl[1]  = '{1,0,0,0,4'h0, 0,4'h1,8'h1E,3'd1,1,0};
        tbl[2]  = '{1,0,0,0,4'h0, 0,4'h1,8'h1E,3'd2,1,0};
        tbl[3]  = '{1,0,0,0,4'h0, 1,4'h1,8'h1E,3'd0,0,0};
        tbl[4]  = '{1,0,0,0,4'h0, 0,4'h2,8'h22,3'd0,1,0};
        tbl[5]  = '{1,0,1,0,4'h0, 1,4'h2,8'h22,3'd0,0,0};
        tbl[6]  = '{1,0,0,0,4'h0, 0,4'h3,8'h55,3'd0,1,0};
        tbl[7]  = '{1,0,1,1,4'hA, 1,4'hA,8'h55,3'd0,0,0};
        tbl[8]  = '{1,0,0,0,4'h0, 0,4'hB,8'h33,3'd0,1,0};
        tbl[9]  = '{0,0,0,0,4'h0, 0,4'hB,8'h33,3'd0,1,0};
        tbl[10] = '{0,0,1,1,4'h3, 0,4'hB,8'h33,3'd0,1,0};
        tbl[11] = '{1,0,0,1,4'h3, 0,4'h3,8'h33,3'd1,1,0};
        tbl[12] = '{1,1,1,1,4'h7, 0,4'h3,8'h33,3'd1,0,1};
        tbl[13] = '{1,0,1,1,4'h7, 0,4'h3,8'h33,3'd1,0,1};

        i_reset = 1'b1;
        #1;
        model_reset();
        check_model("reset_state");
        #2 i_reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].run, tbl[i].halt, tbl[i].done, tbl[i].jump, tbl[i].ja);
            compare($sformatf("table[%0d]", i), actual_bus(),
                    {tbl[i].e_en, tbl[i].e_pc, tbl[i].e_ir, tbl[i].e_step,
                     tbl[i].e_exec, tbl[i].e_halt, tbl[i].e_pc});
        end
        // Keep the model aligned with the table's end state.
        m_phase = 2; m_pc = 3; m_step = 1; m_ir = 8'h33;

        async_reset("reset_from_halt");
        apply(1, 0, 0, 0, 4'h0);
        check_model("post_reset_fetch0");

        // Halt together with a jump at pc 5.
        apply(1, 0, 1, 1, 4'h4);
        apply(1, 0, 0, 0, 4'h0);
        check_eq("pc_before_halt", o_pc, 5);
        apply(1, 1, 0, 1, 4'h9);
        check_model("halt_with_jump");
        for (int i = 0; i < 5; i++) begin
            apply(1'($urandom), 0, 1'($urandom), 1'($urandom), 4'($urandom));
            check_eq("halt_pc_hold", o_pc, 5);
            check_model("halt_hold");
        end
        async_reset("reset_leaves_halt");

        // Program counter wrap, then a 4-cycle freeze mid-execute.
        apply(1, 0, 0, 0, 4'h0);
        apply(1, 0, 1, 1, 4'hF);
        apply(1, 0, 0, 0, 4'h0);
        check_eq("pc_wrap", o_pc, 0);
        check_eq("ir_at_F", o_ir, 8'h8F);
        apply(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            apply(0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            check_eq("freeze_step", o_step, 1);
            check_model("freeze");
        end
        apply(1, 0, 0, 0, 4'h0);
        check_eq("resume_step", o_step, 2);

        // Asynchronous reset while on execute step 1.
        apply(1, 0, 0, 0, 4'h0);
        apply(1, 0, 0, 0, 4'h0);
        apply(1, 0, 0, 0, 4'h0);
        check_eq("pre_reset_step", o_step, 1);
        async_reset("async_reset_exec");

        // Randomized run against the model.
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(7, 0) != 0), ($urandom_range(15, 0) == 0),
                  ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0), 4'($urandom));
            check_model("random");
            if (m_phase == 2 && $urandom_range(3, 0) == 0) async_reset("random_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, program address width (16-entry program store).
REQ-002 SHALL have parameter EXEC_STEPS, default 3, maximum execute microsteps per instruction (range 1..7).
REQ-003 SHALL have port i_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_run  input  1  clock-enable; when low, all state frozen, outputs held.
REQ-006 SHALL have port i_halt  input  1  decoded HLT from execute logic, sampled in EXEC.
REQ-007 SHALL have port i_done  input  1  early end-of-instruction from execute logic, sampled in EXEC.
REQ-008 SHALL have port i_jump  input  1  load program counter, sampled in EXEC.
REQ-009 SHALL have port i_jump_addr  input  ADDR_W  jump target.
REQ-010 SHALL have port i_rom_data  input  8  instruction word from program store.
REQ-011 SHALL have port o_rom_en  output  1  program store read enable (store output undriven when low).
REQ-012 SHALL have port o_rom_addr  output  ADDR_W  program store address.
REQ-013 SHALL have port o_ir  output  8  instruction register.
REQ-014 SHALL have port o_step  output  3  current execute microstep.
REQ-015 SHALL have port o_exec  output  1  high while in EXEC.
REQ-016 SHALL have port o_halted  output  1  high while in HALT.
REQ-017 SHALL have port o_pc  output  ADDR_W  program counter.

Function
REQ-018 SHALL implement states FETCH, EXEC, HALT; outputs Moore-decoded from registered state.
REQ-019 In FETCH, o_rom_en SHALL be 1 and o_rom_addr SHALL equal o_pc; in EXEC and HALT o_rom_en SHALL be 0, o_rom_addr SHALL equal o_pc.
REQ-020 On a FETCH edge with i_run=1: o_ir <= i_rom_data, o_pc <= o_pc+1 modulo 2^ADDR_W, o_step <= 0, state <= EXEC (fetch latency exactly 1 cycle).
REQ-021 On an EXEC edge with i_run=1 and i_halt=1: state <= HALT, o_pc, o_ir, o_step unchanged; i_jump and i_done ignored.
REQ-022 On an EXEC edge with i_run=1, i_halt=0, i_jump=1: o_pc <= i_jump_addr.
REQ-023 On an EXEC edge with i_run=1, i_halt=0, and (i_done=1 or o_step==EXEC_STEPS-1): state <= FETCH, o_step <= 0; else o_step <= o_step+1.
REQ-024 Jump and end-of-instruction on the same edge SHALL both take effect; the next FETCH reads i_jump_addr.
REQ-025 Program counter wrap: o_pc=2^ADDR_W-1 fetched SHALL yield o_pc=0, no flag, no stall.
REQ-026 HALT SHALL be left only by reset; i_run, i_jump, i_done ignored there.
REQ-027 With i_run=0, no register SHALL change in any state; resuming continues exactly where frozen.

Reset
REQ-028 Asserting i_reset SHALL immediately, without a clock, force state=FETCH, o_pc=0, o_ir=8'h00, o_step=0, hence o_rom_en=1, o_rom_addr=0, o_exec=0, o_halted=0.
REQ-029 Reset mid-EXEC or in HALT SHALL discard the instruction in flight; first post-reset rising edge with i_run=1 fetches address 0.

Structure
REQ-030 Shared package ben_cpu_pkg SHALL hold ADDR_W default, instruction width 8, step width 3, and the FETCH/EXEC/HALT state encoding.
REQ-031 Program counter (load, increment, wrap, enable) SHALL be a sub-module named program_counter; remaining logic flat.

Verification
REQ-032 Reset, ROM[0]=8'h1E, i_run=1, no i_done -> cycle 1 o_rom_en=1 addr 0; cycle 2 o_ir=8'h1E, o_pc=1, o_step=0; steps 0,1,2 then FETCH at addr 1 (EXEC_STEPS=3).
REQ-033 i_done=1 at o_step=0 -> next cycle FETCH, instruction takes 2 cycles total.
REQ-034 i_jump=1, i_jump_addr=4'hA with i_done=1 -> next FETCH o_rom_addr=4'hA, o_pc=4'hB after it.
REQ-035 i_halt=1 together with i_jump=1 at o_pc=5 -> o_halted=1, o_pc stays 5 indefinitely, o_rom_en=0; i_reset -> FETCH at 0.
REQ-036 Straight-line run through o_pc=4'hF -> after fetch o_pc=0; i_run=0 for 4 cycles mid-EXEC -> o_step, o_pc, o_ir unchanged, resumes on same step.
REQ-037 i_reset pulse asynchronous to i_clk during EXEC step 1 -> outputs reach reset values before next edge.
